p4_mem_stage: RTL and testbench

P4_MEM_STAGE -- requirements
Module: p4_mem_stage

---
 rtl/p4_mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_p4_mem_stage.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_mem_stage.sv
// Pipeline MEM stage: passes ALU results through, or runs one load/store on a
// ready/valid memory port with IDLE -> REQ -> RESP sequencing, stalling upstream.
module p4_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU,
    input  logic [31:0] writeData,
    input  logic [4:0]  inst3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        valid_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [31:0] readData_out,
    output logic [31:0] ALU_out,
    output logic [4:0]  inst3_out,
    output logic        stall,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        mem_req_s, stall_s, valid_s, misalign_s;
    logic        is_mem_s, legal_s;

    function automatic logic op_legal(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] off);
        logic ok_s;
        ok_s = 1'b0;
        if (rd && !wr) begin
            case (f3)
                3'b000, 3'b100: ok_s = 1'b1;
                3'b001, 3'b101: ok_s = ~off[0];
                3'b010:         ok_s = (off == 2'b00);
                default:        ok_s = 1'b0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                3'b000:  ok_s = 1'b1;
                3'b001:  ok_s = ~off[0];
                3'b010:  ok_s = (off == 2'b00);
                default: ok_s = 1'b0;
            endcase
        end else begin
            ok_s = 1'b0;
        end
        return ok_s;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s_s;
        case (f3)
            3'b000:  s_s = 4'b0001 << off;
            3'b001:  s_s = 4'b0011 << off;
            3'b010:  s_s = 4'b1111;
            default: s_s = 4'b0000;
        endcase
        return s_s;
    endfunction

    // Replicating the store data lets the strobes alone pick the active lanes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d_s;
        case (f3)
            3'b000:  d_s = {4{wd[7:0]}};
            3'b001:  d_s = {2{wd[15:0]}};
            default: d_s = wd;
        endcase
        return d_s;
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh_s;
        logic [31:0] res_s;
        sh_s = word >> {off, 3'b000};
        case (f3)
            3'b000:  res_s = {{24{sh_s[7]}}, sh_s[7:0]};
            3'b001:  res_s = {{16{sh_s[15]}}, sh_s[15:0]};
            3'b010:  res_s = word;
            3'b100:  res_s = {24'd0, sh_s[7:0]};
            3'b101:  res_s = {16'd0, sh_s[15:0]};
            default: res_s = 32'd0;
        endcase
        return res_s;
    endfunction

    assign is_mem_s  = MemRead | MemWrite;
    assign legal_s   = op_legal(MemRead, MemWrite, funct3, ALU[1:0]);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_req   = mem_req_s  & ~rst;
    assign stall     = stall_s    & ~rst;
    assign valid_out = valid_s    & ~rst;
    assign misalign  = misalign_s & ~rst;

    // State and latched-operation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            wstrb_q    <= 4'b0000;
            funct3_q   <= 3'b000;
            rd_q       <= 5'd0;
            we_q       <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wstrb_q    <= wstrb_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    // Next-state, latch capture and output decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        wstrb_d      = wstrb_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        we_d         = we_q;
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        mem_req_s    = 1'b0;
        stall_s      = 1'b0;
        valid_s      = 1'b0;
        misalign_s   = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = 32'd0;
        mem_wstrb    = 4'b0000;
        RegWrite_out = 1'b0;
        MemtoReg_out = 1'b0;
        readData_out = 32'd0;
        ALU_out      = 32'd0;
        inst3_out    = 5'd0;
        case (state_q)
            IDLE: begin
                if (valid_in && !is_mem_s) begin
                    valid_s      = 1'b1;
                    RegWrite_out = RegWrite;
                    MemtoReg_out = MemtoReg;
                    ALU_out      = ALU;
                    inst3_out    = inst3;
                end else if (valid_in && legal_s) begin
                    addr_d     = ALU;
                    funct3_d   = funct3;
                    we_d       = MemWrite;
                    regwrite_d = RegWrite;
                    memtoreg_d = MemtoReg;
                    rd_d       = inst3;
                    wdata_d    = MemWrite ? store_data(funct3, writeData) : 32'd0;
                    wstrb_d    = MemWrite ? store_strobe(funct3, ALU[1:0]) : 4'b0000;
                    rdata_d    = 32'd0;
                    stall_s    = 1'b1;
                    state_d    = REQ;
                end else if (valid_in) begin
                    // Faulting op retires immediately with its register write suppressed.
                    misalign_s   = 1'b1;
                    valid_s      = 1'b1;
                    MemtoReg_out = MemtoReg;
                    ALU_out      = ALU;
                    inst3_out    = inst3;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                mem_req_s = 1'b1;
                stall_s   = 1'b1;
                mem_we    = we_q;
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
                if (mem_ready) begin
                    rdata_d = we_q ? 32'd0 : load_format(mem_rdata, funct3_q, addr_q[1:0]);
                    state_d = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                valid_s      = 1'b1;
                RegWrite_out = regwrite_q;
                MemtoReg_out = memtoreg_q;
                ALU_out      = addr_q;
                inst3_out    = rd_q;
                readData_out = rdata_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_p4_mem_stage.sv
// Self-checking bench for p4_mem_stage: directed scenarios plus randomized ops
// checked against a byte-lane reference model of loads, stores and legality.
module tb_p4_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [2:0]  funct3;
    logic [31:0] ALU, writeData, mem_rdata;
    logic [4:0]  inst3;
    logic        mem_ready;
    logic        mem_req, mem_we, valid_out, RegWrite_out, MemtoReg_out, stall, misalign;
    logic [31:0] mem_addr, mem_wdata, readData_out, ALU_out;
    logic [3:0]  mem_wstrb;
    logic [4:0]  inst3_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    p4_mem_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .funct3(funct3), .ALU(ALU),
        .writeData(writeData), .inst3(inst3), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .valid_out(valid_out),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .readData_out(readData_out), .ALU_out(ALU_out), .inst3_out(inst3_out),
        .stall(stall), .misalign(misalign)
    );

    // Access size in bytes of a named load/store encoding; 0 for unknown.
    function automatic int unsigned op_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_legal(input logic r, input logic w, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (r == w) return 1'b0;
        if (r && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (w && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        return (a % op_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [31:0] a);
        int unsigned s;
        int unsigned o;
        longint      v;
        longint      b;
        s = op_size(f3);
        o = a % 4;
        v = 0;
        for (int k = 0; k < int'(s); k++) begin
            b = longint'((rdata >> (8 * (int'(o) + k))) & 32'hFF);
            v = v + (b << (8 * k));
        end
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * s - 1)))
            v = v - (longint'(1) << (8 * s));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m;
        int unsigned o;
        m = 4'b0000;
        o = a % 4;
        for (int k = 0; k < int'(op_size(f3)); k++) m[int'(o) + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        int          s;
        s = int'(op_size(f3));
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % s) +: 8];
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction to completion and checks it against the model.
    task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                          input int wait_n, input logic [4:0] rd, input logic rw, input logic m2r,
                          output int lat, output int stall_cnt, output int req_cnt,
                          output logic [31:0] rdout);
        logic [31:0] exp_rd;
        bit          done;
        lat = 0; stall_cnt = 0; req_cnt = 0; rdout = 32'd0; done = 1'b0;
        valid_in = 1'b1; MemRead = r; MemWrite = w; funct3 = f3; ALU = a; writeData = wd;
        inst3 = rd; RegWrite = rw; MemtoReg = m2r; mem_ready = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        if (!r && !w) begin
            tests_run++;
            if (valid_out !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || misalign !== 1'b0 ||
                ALU_out !== a || inst3_out !== rd || RegWrite_out !== rw ||
                MemtoReg_out !== m2r || readData_out !== 32'd0) begin
                tests_failed++;
                $display("FAIL pass_through: got v=%b st=%b rq=%b mis=%b alu=%h rd=%0d rw=%b m2r=%b rdata=%h, want 1 0 0 0 %h %0d %b %b 0",
                         valid_out, stall, mem_req, misalign, ALU_out, inst3_out, RegWrite_out,
                         MemtoReg_out, readData_out, a, rd, rw, m2r);
            end
            lat = 1;
            step();
        end else if (!model_legal(r, w, f3, a)) begin
            tests_run++;
            if (misalign !== 1'b1 || valid_out !== 1'b1 || RegWrite_out !== 1'b0 ||
                readData_out !== 32'd0 || stall !== 1'b0 || mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_op: got mis=%b v=%b rw=%b rdata=%h st=%b rq=%b, want 1 1 0 0 0 0 (r=%b w=%b f3=%b a=%h)",
                         misalign, valid_out, RegWrite_out, readData_out, stall, mem_req, r, w, f3, a);
            end
            step();
            valid_in = 1'b0; mem_ready = 1'b0;
            @(negedge clk);
            tests_run++;
            if (misalign !== 1'b0 || mem_req !== 1'b0 || valid_out !== 1'b0 || stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_after: got mis=%b rq=%b v=%b st=%b, want all 0",
                         misalign, mem_req, valid_out, stall);
            end
            lat = 1;
            step();
        end else begin
            tests_run++;
            if (stall !== 1'b1 || valid_out !== 1'b0 || mem_req !== 1'b0 || misalign !== 1'b0) begin
                tests_failed++;
                $display("FAIL accept: got st=%b v=%b rq=%b mis=%b, want 1 0 0 0",
                         stall, valid_out, mem_req, misalign);
            end
            lat = 1;
            stall_cnt = int'(stall);
            step();
            exp_rd = w ? 32'd0 : exp_load(rdata, f3, a);
            for (int c = 0; c < 24 && !done; c++) begin
                mem_ready = (c == wait_n);
                mem_rdata = (c == wait_n) ? rdata : $urandom;
                @(negedge clk);
                lat++;
                if (valid_out === 1'b1) begin
                    done = 1'b1;
                    rdout = readData_out;
                    tests_run++;
                    if (stall !== 1'b0 || mem_req !== 1'b0 || readData_out !== exp_rd ||
                        ALU_out !== a || inst3_out !== rd || RegWrite_out !== rw ||
                        MemtoReg_out !== m2r) begin
                        tests_failed++;
                        $display("FAIL resp: got st=%b rq=%b rdata=%h alu=%h rd=%0d rw=%b m2r=%b, want 0 0 %h %h %0d %b %b",
                                 stall, mem_req, readData_out, ALU_out, inst3_out, RegWrite_out,
                                 MemtoReg_out, exp_rd, a, rd, rw, m2r);
                    end
                end else begin
                    req_cnt += int'(mem_req);
                    stall_cnt += int'(stall);
                    tests_run++;
                    if (mem_req !== 1'b1 || stall !== 1'b1 || mem_we !== w ||
                        mem_addr !== (a & 32'hFFFF_FFFC) ||
                        (w && (mem_wstrb !== exp_strb(f3, a) || mem_wdata !== exp_wdata(f3, wd)))) begin
                        tests_failed++;
                        $display("FAIL req_cycle%0d: got rq=%b st=%b we=%b addr=%h strb=%b wdata=%h, want 1 1 %b %h %b %h",
                                 c, mem_req, stall, mem_we, mem_addr, mem_wstrb, mem_wdata, w,
                                 a & 32'hFFFF_FFFC, exp_strb(f3, a), exp_wdata(f3, wd));
                    end
                end
                step();
            end
            tests_run++;
            if (!done || lat != wait_n + 3) begin
                tests_failed++;
                $display("FAIL latency: got %0d cycles (resp seen=%0d), want %0d", lat, done, wait_n + 3);
            end
            valid_in = 1'b0; mem_ready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (valid_out !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL after_resp: got v=%b st=%b rq=%b, want 0 0 0", valid_out, stall, mem_req);
            end
            step();
        end
        valid_in = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        int l, s, q;
        logic [31:0] rv;
        rst = 1'b1; valid_in = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
        ALU = 32'h0000_0010; mem_ready = 1'b1;
        step();
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || valid_out !== 1'b0 || misalign !== 1'b0 ||
            readData_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rq=%b st=%b v=%b mis=%b rdata=%h, want all 0",
                     mem_req, stall, valid_out, misalign, readData_out);
        end
        step();
        rst = 1'b0;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 0, 5'd3, 1'b1, 1'b1,
               l, s, q, rv);
        tests_run++;
        if (rv !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL first_after_reset: got rdata=%h, want cafef00d", rv);
        end
    endtask

    task automatic test_idle();
        valid_in = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; funct3 = 3'b111; ALU = 32'hFFFF_FFFF;
        mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (valid_out !== 1'b0 || stall !== 1'b0 || misalign !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_novalid: got v=%b st=%b mis=%b rq=%b, want 0 0 0 0",
                     valid_out, stall, misalign, mem_req);
        end
        step();
        mem_ready = 1'b0;
    endtask

    task automatic test_alu_pass();
        int l, s, q;
        logic [31:0] rv;
        run_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 32'd0, 0, 5'd5, 1'b1, 1'b0, l, s, q, rv);
        run_op(1'b0, 1'b0, 3'b101, 32'h8765_4321, 32'd0, 32'd0, 0, 5'd31, 1'b0, 1'b1, l, s, q, rv);
    endtask

    task automatic test_lb();
        int l, s, q;
        logic [31:0] rv;
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h1111_2222, 32'h80FF_1234, 0, 5'd9, 1'b1,
               1'b1, l, s, q, rv);
        tests_run++;
        if (rv !== 32'hFFFF_FF80 || s != 2 || l != 3) begin
            tests_failed++;
            $display("FAIL lb_directed: got rdata=%h stall_cycles=%0d lat=%0d, want ffffff80 2 3", rv, s, l);
        end
    endtask

    task automatic test_sh();
        int l, s, q;
        logic [31:0] rv;
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hABCD_5678, 32'hDEAD_BEEF, 0, 5'd0, 1'b0,
               1'b0, l, s, q, rv);
        tests_run++;
        if (rv !== 32'd0 || exp_strb(3'b001, 32'h2002) !== 4'b1100 ||
            exp_wdata(3'b001, 32'hABCD_5678) !== 32'h5678_5678) begin
            tests_failed++;
            $display("FAIL sh_directed: got rdata=%h, want 0", rv);
        end
    endtask

    task automatic test_lhu_wait();
        int l, s, q;
        logic [31:0] rv;
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0040, 32'd0, 32'h1357_9BDF, 4, 5'd12, 1'b1, 1'b1,
               l, s, q, rv);
        tests_run++;
        if (q != 5 || l != 7 || rv !== 32'h0000_9BDF) begin
            tests_failed++;
            $display("FAIL lhu_wait: got req_cycles=%0d lat=%0d rdata=%h, want 5 7 00009bdf", q, l, rv);
        end
    endtask

    task automatic test_misalign();
        int l, s, q;
        logic [31:0] rv;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0041, 32'd0, 32'd0, 0, 5'd4, 1'b1, 1'b1, l, s, q, rv);
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0043, 32'h55AA_55AA, 32'd0, 0, 5'd4, 1'b1, 1'b0, l, s, q, rv);
        run_op(1'b1, 1'b1, 3'b000, 32'h0000_0100, 32'd0, 32'd0, 0, 5'd4, 1'b1, 1'b0, l, s, q, rv);
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0, 5'd4, 1'b1, 1'b0, l, s, q, rv);
    endtask

    task automatic test_reset_in_req();
        valid_in = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALU = 32'h0000_0100;
        inst3 = 5'd8; RegWrite = 1'b1; MemtoReg = 1'b1; mem_ready = 1'b0;
        step();
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_req_pre: got rq=%b, want 1", mem_req);
        end
        step();
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_req_during: got rq=%b v=%b, want 0 0", mem_req, valid_out);
        end
        step();
        rst = 1'b0; mem_ready = 1'b0; MemRead = 1'b0; ALU = 32'h0000_ABCD; inst3 = 5'd7;
        MemtoReg = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || valid_out !== 1'b1 || ALU_out !== 32'h0000_ABCD ||
            inst3_out !== 5'd7 || readData_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_req_add: got rq=%b st=%b v=%b alu=%h rd=%0d rdata=%h, want 0 0 1 0000abcd 7 0",
                     mem_req, stall, valid_out, ALU_out, inst3_out, readData_out);
        end
        step();
        valid_in = 1'b0;
        @(negedge clk);
        tests_run++;
        if (valid_out !== 1'b0 || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_req_noresp: got v=%b rq=%b, want 0 0", valid_out, mem_req);
        end
        step();
    endtask

    task automatic test_random_ops();
        int          l, s, q;
        logic [31:0] rv, rn, a;
        logic [2:0]  f3;
        logic        r, w;
        for (int i = 0; i < 80; i++) begin
            rn = $urandom;
            a  = $urandom;
            case (rn[1:0])
                2'b00: begin r = 1'b0; w = 1'b0; f3 = rn[4:2]; end
                2'b01: begin
                    r = 1'b1; w = 1'b0;
                    case (rn[4:2] % 5)
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                    a = a - (a % op_size(f3));
                end
                2'b10: begin
                    r = 1'b0; w = 1'b1;
                    case (rn[4:2] % 3)
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        default: f3 = 3'b010;
                    endcase
                    a = a - (a % op_size(f3));
                end
                default: begin r = rn[5]; w = rn[6]; f3 = rn[9:7]; end
            endcase
            run_op(r, w, f3, a, $urandom, $urandom, int'(rn[11:10]), rn[16:12], rn[17], rn[18],
                   l, s, q, rv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
        MemtoReg = 1'b0; funct3 = 3'b000; ALU = 32'd0; writeData = 32'd0; inst3 = 5'd0;
        mem_rdata = 32'd0; mem_ready = 1'b0;
        step();
        step();
        test_reset();
        test_idle();
        test_alu_pass();
        test_lb();
        test_sh();
        test_lhu_wait();
        test_misalign();
        test_reset_in_req();
        test_random_ops();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
